// File: rtl/simon_key_sequencer_if.sv
// Bundle between the SIMON key-schedule sequencer and its neighbours.
//   master : the sequencer. It takes in the master-key load, round-key
//            backpressure and the expansion result. It drives the
//            round-key stream and the key window / round count that
//            feed the expansion stage.
//   slave  : the environment (load source, round datapath, expansion stage).
// Signals:
//   key_load / key_in        master-key load request and key (word 0 = k0)
//   rk_valid / rk_ready      round-key handshake
//   rk / rk_round            current round key and its index
//   done / busy              schedule status
//   exp_count / exp_keys     registered round count and window to expansion
//   exp_word                 expansion result k(i+M)
interface simon_key_sequencer_if #(
  parameter int N  = 16,
  parameter int M  = 4,
  parameter int Co = 5
);
  logic                  key_load;
  logic [M-1:0][N-1:0]   key_in;
  logic                  rk_ready;
  logic                  rk_valid;
  logic [N-1:0]          rk;
  logic [Co-1:0]         rk_round;
  logic                  done;
  logic                  busy;
  logic [Co-1:0]         exp_count;
  logic [M-1:0][N-1:0]   exp_keys;
  logic [N-1:0]          exp_word;

  modport master (
    input  key_load, key_in, rk_ready, exp_word,
    output rk_valid, rk, rk_round, done, busy, exp_count, exp_keys
  );

  modport slave (
    output key_load, key_in, rk_ready, exp_word,
    input  rk_valid, rk, rk_round, done, busy, exp_count, exp_keys
  );
endinterface

// File: rtl/simon_key_sequencer.sv
// SIMON key-schedule sequencer.
// It holds the M-word key window and feeds it, together with the round count,
// to an external combinational expansion stage. At each accepted round key it
// shifts the window down one word and captures the expansion result into the
// top word. It streams one round key per cycle over rk_valid/rk_ready.
// Ports:
//   clk     rising-edge clock
//   nReset  synchronous active-low reset
//   bus     simon_key_sequencer_if.master (load, round-key stream, expansion)

// One word of the key window. The load takes priority over the shift.
module simon_key_word #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         nReset,
  input  logic         load,
  input  logic         shift,
  input  logic [N-1:0] load_val,
  input  logic [N-1:0] shift_val,
  output logic [N-1:0] q
);
  always_ff @(posedge clk) begin
    if (!nReset)    q <= '0;
    else if (load)  q <= load_val;
    else if (shift) q <= shift_val;
  end
endmodule

module simon_key_sequencer #(
  parameter int N  = 16,
  parameter int M  = 4,
  parameter int T  = 32,
  parameter int Co = 5
) (
  input  logic                   clk,
  input  logic                   nReset,
  simon_key_sequencer_if.master  bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  localparam logic [Co-1:0] LAST = Co'(T - 1);

  state_t        state_q, state_d;
  logic [Co-1:0] round_q;
  logic [N-1:0]  window [M];

  logic rk_valid, busy, done;
  logic hs, last, shift;

  // A load in the same cycle as a ready round key takes priority, so that
  // key is not counted as delivered.
  assign hs    = rk_valid & bus.rk_ready & ~bus.key_load;
  assign last  = (round_q == LAST);
  // The final handshake only moves the FSM to DONE. The window and round
  // stay frozen so that round never passes T-1.
  assign shift = hs & ~last;

  // ---------------- state register ----------------
  always_ff @(posedge clk) begin
    if (!nReset) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // ---------------- next state ----------------
  always_comb begin
    state_d = state_q;
    if (bus.key_load) state_d = RUN;
    else begin
      unique case (state_q)
        RUN:     if (hs && last) state_d = DONE;
        default: state_d = state_q;
      endcase
    end
  end

  // ---------------- outputs ----------------
  always_comb begin
    rk_valid = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state_q)
      RUN:     begin rk_valid = 1'b1; busy = 1'b1; end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // ---------------- round counter ----------------
  always_ff @(posedge clk) begin
    if (!nReset)           round_q <= '0;
    else if (bus.key_load) round_q <= '0;
    else if (shift)        round_q <= round_q + 1'b1;
  end

  // ---------------- key window ----------------
  // Each word shifts down one place. The top word takes the expansion result.
  for (genvar j = 0; j < M; j++) begin : g_win
    logic [N-1:0] shin;
    if (j == M - 1) begin : g_top
      assign shin = bus.exp_word;
    end else begin : g_mid
      assign shin = window[j+1];
    end
    simon_key_word #(.N(N)) u_word (
      .clk       (clk),
      .nReset    (nReset),
      .load      (bus.key_load),
      .shift     (shift),
      .load_val  (bus.key_in[j]),
      .shift_val (shin),
      .q         (window[j])
    );
  end

  always_comb begin
    bus.exp_keys = '0;
    for (int j = 0; j < M; j++) bus.exp_keys[j] = window[j];
  end

  // The window is all zero after reset, so rk is zero in IDLE without muxing.
  assign bus.exp_count = round_q;
  assign bus.rk        = window[0];
  assign bus.rk_round  = round_q;
  assign bus.rk_valid  = rk_valid;
  assign bus.busy      = busy;
  assign bus.done      = done;
endmodule

// File: tb/tb_simon_key_sequencer.sv
module tb_simon_key_sequencer;
  localparam int N = 16, M = 4, T = 32, Co = 5;

  logic clk = 1'b0;
  logic nReset;
  int   tests = 0;
  int   fails = 0;

  logic [61:0]         zseq = 62'b11111010001001010110000111001101111101000100101011000011100110;
  logic [15:0]         gold [0:T+M];
  logic [3:0][15:0]    key1, key2;

  simon_key_sequencer_if #(.N(N), .M(M), .Co(Co)) bus ();

  simon_key_sequencer #(.N(N), .M(M), .T(T), .Co(Co)) dut (
    .clk    (clk),
    .nReset (nReset),
    .bus    (bus.master)
  );

  always #5 clk = ~clk;

  // SIMON32/64 key expansion: k(i+4) = ~k(i) ^ 3 ^ z0[i] ^ t ^ ror(t,1), t = ror(k(i+3),3) ^ k(i+1)
  function automatic logic [15:0] simon_exp(input logic [3:0][15:0] w, input logic [4:0] i);
    logic [15:0] t;
    int idx;
    idx = 61 - int'(i);
    t = {w[3][2:0], w[3][15:3]} ^ w[1];
    t = t ^ {t[0], t[15:1]};
    return 16'hfffc ^ {15'b0, zseq[idx]} ^ w[0] ^ t;
  endfunction

  always_comb bus.exp_word = simon_exp(bus.exp_keys, bus.exp_count);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_gold(input logic [3:0][15:0] k);
    for (int i = 0; i < M; i++) gold[i] = k[i];
    for (int i = 0; i <= T + M - M - 1; i++)
      gold[i+M] = simon_exp({gold[i+3], gold[i+2], gold[i+1], gold[i]}, 5'(i));
  endtask

  task automatic chk_round(input int r);
    chk($sformatf("valid@%0d", r), 64'(bus.rk_valid), 64'd1);
    chk($sformatf("round@%0d", r), 64'(bus.rk_round), 64'(r));
    chk($sformatf("rk@%0d", r), 64'(bus.rk), 64'(gold[r]));
    chk($sformatf("cnt@%0d", r), 64'(bus.exp_count), 64'(r));
    chk($sformatf("win@%0d", r), 64'(bus.exp_keys), {gold[r+3], gold[r+2], gold[r+1], gold[r]});
  endtask

  task automatic load(input logic [3:0][15:0] k);
    bus.key_in   = k;
    bus.key_load = 1'b1;
    tick();
    bus.key_load = 1'b0;
    set_gold(k);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, 64'(bus.rk_valid), 64'd0);
    chk({tag, "_busy"},  64'(bus.busy),     64'd0);
    chk({tag, "_done"},  64'(bus.done),     64'd0);
    chk({tag, "_cnt"},   64'(bus.exp_count), 64'd0);
    chk({tag, "_keys"},  64'(bus.exp_keys), 64'd0);
  endtask

  initial begin
    key1 = {16'h1918, 16'h1110, 16'h0908, 16'h0100};
    key2 = {16'hdead, 16'hbeef, 16'h1234, 16'h5a5a};
    nReset = 1'b0;
    bus.key_load = 1'b0;
    bus.key_in   = '0;
    bus.rk_ready = 1'b0;

    // reset values
    tick(); tick();
    chk_idle("rst");
    chk("rst_rk", 64'(bus.rk), 64'd0);
    chk("rst_round", 64'(bus.rk_round), 64'd0);

    // rk_ready ignored while idle
    nReset = 1'b1;
    bus.rk_ready = 1'b1;
    tick(); tick();
    chk_idle("idle_rdy");

    // full schedule with ready held high
    load(key1);
    chk("k0_lit", 64'(bus.rk), 64'h0100);
    for (int r = 0; r < T; r++) begin
      chk_round(r);
      if (r == 1) chk("k1_lit", 64'(bus.rk), 64'h0908);
      if (r == 2) chk("k2_lit", 64'(bus.rk), 64'h1110);
      if (r == 3) chk("k3_lit", 64'(bus.rk), 64'h1918);
      if (r == 4) chk("k4_lit", 64'(bus.rk), 64'h71c3);
      chk($sformatf("done_low@%0d", r), 64'(bus.done), 64'd0);
      tick();
    end
    chk("done_set", 64'(bus.done), 64'd1);
    chk("done_busy", 64'(bus.busy), 64'd0);
    chk("done_valid", 64'(bus.rk_valid), 64'd0);
    chk("done_round", 64'(bus.rk_round), 64'(T-1));
    bus.rk_ready = 1'b0;
    tick(); tick();
    chk("done_hold", 64'(bus.done), 64'd1);

    // backpressure at round 7
    bus.rk_ready = 1'b1;
    load(key1);
    chk("reload_done", 64'(bus.done), 64'd0);
    for (int r = 0; r < 7; r++) tick();
    bus.rk_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk_round(7);
    end
    bus.rk_ready = 1'b1;
    for (int r = 7; r <= 12; r++) begin
      chk_round(r);
      if (r < 12) tick();
    end

    // reset mid-run at round 12
    nReset = 1'b0;
    tick();
    chk_idle("midrst");
    nReset = 1'b1;
    tick();
    chk_idle("midrst2");
    load(key2);
    for (int r = 0; r <= 20; r++) begin
      chk_round(r);
      if (r < 20) tick();
    end

    // new load during round 20 abandons the old schedule
    load(key1);
    chk_round(0);
    for (int r = 1; r <= T - 1; r++) begin
      tick();
      chk($sformatf("abandon_done@%0d", r), 64'(bus.done), 64'd0);
    end
    chk_round(T - 1);

    // load coincides with the final handshake: load wins
    bus.key_in   = key2;
    bus.key_load = 1'b1;
    tick();
    bus.key_load = 1'b0;
    set_gold(key2);
    chk("race_done", 64'(bus.done), 64'd0);
    chk_round(0);

    // finish key2, then load from DONE
    for (int r = 0; r < T; r++) tick();
    chk("k2_done", 64'(bus.done), 64'd1);
    chk("k2_last", 64'(bus.rk_round), 64'(T-1));
    load(key1);
    chk("fromdone_done", 64'(bus.done), 64'd0);
    chk("fromdone_busy", 64'(bus.busy), 64'd1);
    chk_round(0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
